aes_key_exp_multi: RTL and testbench

//  Key scheduler for AES-128/192/256, with the key size selected at run time.

---
 rtl/aes_key_exp_multi.sv | 250 +++++++++++++++++++++++++
 tb/tb_aes_key_exp_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_exp_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_key_exp_multi: run-time selectable AES-128/192/256 key expansion     |
// | feeding round keys through a small valid/ready FIFO.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module aes_key_exp_multi #(
  parameter int RK_FIFO_DEPTH = 2,
  parameter int SBOX_REG      = 1
) (
  input  logic         mclk,
  input  logic         arst_n,
  input  logic [255:0] ck_master,
  input  logic [1:0]   key_len,
  input  logic         start,
  input  logic         flush,
  output logic [127:0] rk,
  output logic [3:0]   rk_count,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam int AW = (RK_FIFO_DEPTH > 1) ? $clog2(RK_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(RK_FIFO_DEPTH + 1);
  localparam int EW = 132;
  localparam logic [CW-1:0] C_FULL     = CW'(RK_FIFO_DEPTH);
  localparam logic [AW-1:0] C_LAST_PTR = AW'(RK_FIFO_DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GEN   = 3'd2;
  localparam logic [2:0] S_SBW   = 3'd3;
  localparam logic [2:0] S_STALL = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as v^254 (0 maps to 0), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = v;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  logic [2:0]    state_q, state_d;
  logic          done_q, done_d;
  logic [255:0]  key_q;
  logic [1:0]    klen_q;
  logic [5:0]    i_q;
  logic [2:0]    mod_q;
  logic [7:0]    rcon_q;
  logic [255:0]  win_q;
  logic [95:0]   asm_q;

  logic [EW-1:0] mem_q [RK_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [EW-1:0] last_q;

  logic [2:0]    nk_m1;
  logic [5:0]    last_i;
  logic [31:0]   w_prev, w_back, key_w, sb_in, sub_comb, sub_w, rc_mask;
  logic [31:0]   gen_word, new_word;
  logic          is_rot, needs_sub, push_word, fifo_full, fifo_empty;
  logic          pop, space, word_ok, wr, push, start_acc;
  logic [EW-1:0] head;

  // Window slot k holds w[i-1-k]; w[i-Nk] therefore sits in slot Nk-1.
  always_comb begin
    case (klen_q)
      2'd1: begin
        nk_m1  = 3'd5;
        last_i = 6'd51;
        w_back = win_q[191:160];
      end
      2'd2: begin
        nk_m1  = 3'd7;
        last_i = 6'd59;
        w_back = win_q[255:224];
      end
      default: begin
        nk_m1  = 3'd3;
        last_i = 6'd43;
        w_back = win_q[127:96];
      end
    endcase
  end

  assign w_prev    = win_q[31:0];
  assign key_w     = key_q[{~i_q[2:0], 5'b0} +: 32];
  assign is_rot    = (mod_q == 3'd0);
  assign needs_sub = is_rot || ((klen_q == 2'd2) && (mod_q == 3'd4));
  assign sb_in     = is_rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign sub_comb  = sub_word(sb_in);
  assign rc_mask   = is_rot ? {rcon_q, 24'h0} : 32'h0;
  assign gen_word  = needs_sub ? (w_back ^ sub_w ^ rc_mask) : (w_back ^ w_prev);
  assign new_word  = (state_q == S_LOAD) ? key_w : gen_word;

  generate
    if (SBOX_REG != 0) begin : g_sbox_reg
      logic [31:0] sub_q;
      always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) sub_q <= '0;
        else         sub_q <= sub_comb;
      end
      assign sub_w = sub_q;
    end else begin : g_sbox_comb
      assign sub_w = sub_comb;
    end
  endgenerate

  assign push_word  = &i_q[1:0];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == C_FULL);
  assign head       = mem_q[rd_ptr_q];
  assign pop        = !fifo_empty && rk_ready && !flush;
  // A full FIFO still has room when its head leaves on the same edge.
  assign space      = !fifo_full || pop;
  assign start_acc  = (state_q == S_IDLE) && start && !flush;

  always_comb begin
    case (state_q)
      S_LOAD, S_SBW, S_STALL: word_ok = 1'b1;
      S_GEN:                  word_ok = !(needs_sub && (SBOX_REG != 0));
      default:                word_ok = 1'b0;
    endcase
  end

  assign wr   = word_ok && (!push_word || space) && !flush;
  assign push = wr && push_word;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_LOAD;
      S_LOAD:  if (wr && (i_q[2:0] == nk_m1)) state_d = S_GEN;
      S_GEN: begin
        if (needs_sub && (SBOX_REG != 0)) state_d = S_SBW;
        else if (!wr)                     state_d = S_STALL;
        else if (i_q == last_i)           state_d = S_DRAIN;
      end
      S_SBW, S_STALL: if (wr) state_d = (i_q == last_i) ? S_DRAIN : S_GEN;
      S_DRAIN: begin
        if (pop && (head[131:128] == last_i[5:2])) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      key_q   <= '0;
      klen_q  <= 2'd0;
      i_q     <= 6'd0;
      mod_q   <= 3'd0;
      rcon_q  <= 8'h01;
      win_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_acc) begin
        key_q  <= ck_master;
        klen_q <= (key_len == 2'd3) ? 2'd0 : key_len;
        i_q    <= 6'd0;
        mod_q  <= 3'd0;
        rcon_q <= 8'h01;
      end
      if (wr) begin
        win_q <= {win_q[223:0], new_word};
        asm_q <= {asm_q[63:0], new_word};
        i_q   <= i_q + 6'd1;
        mod_q <= (mod_q == nk_m1) ? 3'd0 : mod_q + 3'd1;
        if ((state_q != S_LOAD) && is_rot) rcon_q <= xtime(rcon_q);
      end
    end
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      for (int k = 0; k < RK_FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {i_q[5:2], asm_q, new_word};
        wr_ptr_q        <= (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_q   <= head;
        rd_ptr_q <= (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // With the FIFO empty the last popped key stays visible.
  assign rk_valid        = !fifo_empty;
  assign {rk_count, rk}  = fifo_empty ? last_q : head;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_exp_multi.sv
`default_nettype none
// Bench for aes_key_exp_multi: reference key schedule built from a log/antilog
// sbox, checked against every accepted round key.
module tb_aes_key_exp_multi;

  logic         mclk = 1'b0;
  logic         arst_n;
  logic [255:0] ck_master;
  logic [1:0]   key_len;
  logic         start, flush, rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_count;
  logic         rk_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_rk [0:14];
  int           exp_nr = 10;
  int           pop_idx = 0;
  int           runs_done = 0;
  bit           done_exp = 1'b0;

  localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  aes_key_exp_multi #(.RK_FIFO_DEPTH(2), .SBOX_REG(1)) dut (
    .mclk(mclk), .arst_n(arst_n), .ck_master(ck_master), .key_len(key_len),
    .start(start), .flush(flush), .rk(rk), .rk_count(rk_count),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .busy(busy), .done(done)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic init_sbox();
    int lg [0:255];
    logic [7:0] ex [0:254];
    logic [7:0] e, inv, s, c;
    c = 8'h63;
    e = 8'h01;
    for (int k = 0; k < 255; k++) begin
      ex[k] = e;
      lg[e] = k;
      e = e ^ xt(e);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic build_model(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
    exp_nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[(7-i)*32 +: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(exp_nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= exp_nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Every accepted key, the done pulse and the post-done state against the model.
  always @(negedge mclk) begin
    if (!arst_n) begin
      done_exp = 1'b0;
    end else begin
      chk("done", 128'(done), 128'(done_exp));
      if (done_exp) begin
        chk("valid_after_done", 128'(rk_valid), 128'(0));
        chk("rk_hold_after_done", rk, exp_rk[exp_nr]);
        chk("busy_after_done", 128'(busy), 128'(0));
        runs_done++;
      end
      done_exp = 1'b0;
      if (start && !busy && !flush) pop_idx = 0;
      if (rk_valid && rk_ready && !flush) begin
        if (pop_idx > exp_nr) begin
          chk("extra_key_count", 128'(rk_count), 128'(15));
        end else begin
          chk("rk", rk, exp_rk[pop_idx]);
          chk("rk_count", 128'(rk_count), 128'(pop_idx));
          if (pop_idx == exp_nr) done_exp = 1'b1;
        end
        pop_idx++;
      end
    end
  end

  // mode 0: always ready, 1: random ready, 2: ready low 20 cycles after first key.
  task automatic run_key(input logic [255:0] key, input logic [1:0] kl, input int mode,
                         input int flush_after);
    int rd;
    bit fin;
    build_model(key, kl);
    rd = runs_done;
    @(posedge mclk); #1;
    ck_master = key;
    key_len   = kl;
    start     = 1'b1;
    rk_ready  = (mode == 2) ? 1'b0 : 1'b1;
    @(posedge mclk); #1;
    start     = 1'b0;
    key_len   = 2'($urandom_range(0, 3));
    ck_master = {8{$urandom()}};
    for (int s = 0; s < 5; s++) begin
      @(negedge mclk);
      chk("latency_valid", 128'(rk_valid), 128'(s == 4));
      if (s == 0) chk("busy_after_start", 128'(busy), 128'(1));
    end
    if (mode == 2) begin
      repeat (20) @(posedge mclk);
      #1 rk_ready = 1'b1;
    end
    fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(posedge mclk); #1;
      rk_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (flush_after >= 0 && pop_idx >= flush_after) begin
        flush = 1'b1;
        @(posedge mclk); #1;
        flush = 1'b0;
        @(negedge mclk);
        chk("valid_after_flush", 128'(rk_valid), 128'(0));
        chk("busy_after_flush", 128'(busy), 128'(0));
        return;
      end
      if (runs_done != rd) fin = 1'b1;
    end
    if (!fin) chk("run_timeout", 128'(pop_idx), 128'(exp_nr + 1));
    else      chk("key_count", 128'(pop_idx), 128'(exp_nr + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_n = 1'b0; ck_master = '0; key_len = 2'd0;
    start = 1'b0; flush = 1'b0; rk_ready = 1'b0;
    #2;
    chk("reset_rk", rk, 128'h0);
    chk("reset_rk_count", 128'(rk_count), 128'(0));
    chk("reset_valid", 128'(rk_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    #10 arst_n = 1'b1;

    init_sbox();
    build_model(K128, 2'd0);
    chk("model_128_r1", exp_rk[1], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    chk("model_128_r10", exp_rk[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    build_model(K192, 2'd1);
    chk("model_192_r12", exp_rk[12], 128'he98ba06f_448c773c_8ecc7204_01002202);
    build_model(K256, 2'd2);
    chk("model_256_r14", exp_rk[14], 128'hfe4890d1_e6188d0b_046df344_706c631e);

    run_key(K128, 2'd0, 0, -1);
    run_key(K192, 2'd1, 0, -1);
    run_key(K256, 2'd2, 0, -1);
    run_key(K128, 2'd0, 2, -1);
    run_key(K128, 2'd0, 0, 4);
    run_key(K256, 2'd2, 0, -1);

    // flush wins over start in IDLE
    @(posedge mclk); #1;
    start = 1'b1; flush = 1'b1; ck_master = K192; key_len = 2'd1;
    @(posedge mclk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge mclk);
    chk("flush_beats_start", 128'(busy), 128'(0));

    // start while busy, then async reset mid-expansion, then a clean rerun
    build_model(K128, 2'd0);
    @(posedge mclk); #1;
    ck_master = K128; key_len = 2'd0; start = 1'b1; rk_ready = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0;
    repeat (8) @(posedge mclk);
    #1 start = 1'b1; key_len = 2'd2; ck_master = {8{$urandom()}};
    @(posedge mclk); #1;
    start = 1'b0;
    @(negedge mclk);
    chk("busy_ignore_start", 128'(busy), 128'(1));
    repeat (4) @(posedge mclk);
    #2 arst_n = 1'b0;
    #1;
    chk("async_rst_rk", rk, 128'h0);
    chk("async_rst_rk_count", 128'(rk_count), 128'(0));
    chk("async_rst_valid", 128'(rk_valid), 128'(0));
    chk("async_rst_busy", 128'(busy), 128'(0));
    chk("async_rst_done", 128'(done), 128'(0));
    @(posedge mclk);
    #3 arst_n = 1'b1;
    run_key(K128, 2'd0, 0, -1);

    for (int n = 0; n < 4; n++)
      run_key({$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()},
              2'($urandom_range(0, 3)), 1, -1);

    repeat (3) @(posedge mclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
